// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI frame receiver.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package spi_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int ADDR_W         = 7;
    localparam int DATA_W         = 8;

    // Field positions inside the {rw, addr, data} frame
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop pin synchroniser with a trailing delay flop for edge detection.
// Latency: STAGES clk cycles to sync_o; rise_o/fall_o are combinational from sync_o.
// Backpressure: none; the pin is sampled every cycle.
module sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Shift the asynchronous pin through the synchroniser chain, then delay one more cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~dly_q;
    assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 receiver: synchronises SCLK/nCS/COPI and frames 16-bit {rw, addr, data} words.
// Latency: frame_valid/frame_err pulse SYNC_STAGES+2 clk edges after nCS high is first sampled.
// Backpressure: none; pulses last one cycle and the consumer must take them as they come.
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ncs,
    input  logic              copi,
    output logic              frame_valid,
    output logic              frame_rw,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err,
    output logic              busy
);

    // Counter must reach FRAME_BITS+1 so over-long frames are distinguishable
    localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_rise;
    logic sclk_s_unused;
    logic sclk_fall_unused;
    logic ncs_rise;
    logic ncs_fall;
    logic ncs_s_unused;
    logic copi_s;
    logic copi_rise_unused;
    logic copi_fall_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .sync_o (sclk_s_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall_unused)
    );

    // nCS idles high so an already-low pin after reset looks like a fresh falling edge
    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ncs),
        .sync_o (ncs_s_unused),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (copi),
        .sync_o (copi_s),
        .rise_o (copi_rise_unused),
        .fall_o (copi_fall_unused)
    );

    state_t                  state_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    frame_valid_q;
    logic                    frame_err_q;
    logic                    frame_rw_q;
    logic [ADDR_W-1:0]       frame_addr_q;
    logic [DATA_W-1:0]       frame_data_q;

    // Frame FSM: collect bits while nCS is low, then judge the bit count for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_rw_q    <= 1'b0;
            frame_addr_q  <= '0;
            frame_data_q  <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // An SCLK edge coinciding with nCS fall is dropped: counting starts from 0
                    if (ncs_fall) begin
                        state_q <= SHIFT;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        // An SCLK edge coinciding with nCS rise is discarded
                        state_q <= DONE;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
                        if (cnt_q != CNT_SAT) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (cnt_q == CNT_FULL) begin
                        frame_valid_q <= 1'b1;
                        frame_rw_q    <= shift_q[RW_BIT];
                        frame_addr_q  <= shift_q[ADDR_MSB:ADDR_LSB];
                        frame_data_q  <= shift_q[DATA_W-1:0];
                    end else begin
                        frame_err_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_rw    = frame_rw_q;
    assign frame_addr  = frame_addr_q;
    assign frame_data  = frame_data_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: directed SPI frames with hand-computed results.
// Latency: expects each pulse SYNC_STAGES+2 clk edges after nCS high is first sampled.
// Backpressure: none; the monitor checks every pulse the DUT presents.
module tb_spi_frame_rx;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ncs = 1'b1;
    logic       copi = 1'b0;
    logic       frame_valid;
    logic       frame_rw;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic        err;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [31:0] rise_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] cyc = 0;

    spi_frame_rx #(.SYNC_STAGES(SYNC), .FRAME_BITS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .ncs         (ncs),
        .copi        (copi),
        .frame_valid (frame_valid),
        .frame_rw    (frame_rw),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one SPI mode-0 transaction of nbits (MSB first) at SCLK = clk/8
    task automatic send(input logic [31:0] val, input int nbits, input logic e,
                        input logic rw, input logic [6:0] a, input logic [7:0] d);
        exp_t x;
        ncs = 1'b0;
        clk_n(8);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = val[i];
            clk_n(4);
            sclk = 1'b1;
            clk_n(4);
            sclk = 1'b0;
        end
        clk_n(4);
        ncs = 1'b1;
        x.err = e; x.rw = rw; x.addr = a; x.data = d; x.rise_cyc = cyc;
        sb_q.push_back(x);
        clk_n(16);
    endtask

    // Monitor: every pulse must match the oldest expectation, including its latency
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (frame_valid || frame_err)) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got valid=%0d err=%0d expected no pulse (cycle %0d)",
                         frame_valid, frame_err, cyc);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind", {30'd0, frame_valid, frame_err}, {30'd0, ~e.err, e.err});
                check("frame_rw",   {31'd0, frame_rw},   {31'd0, e.rw});
                check("frame_addr", {25'd0, frame_addr}, {25'd0, e.addr});
                check("frame_data", {24'd0, frame_data}, {24'd0, e.data});
                check("latency",    cyc - e.rise_cyc,    SYNC + 2);
            end
        end
    end

    initial begin
        int waited;

        // Reset state
        clk_n(3);
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_err",   {31'd0, frame_err},   32'd0);
        check("rst_rw",    {31'd0, frame_rw},    32'd0);
        check("rst_addr",  {25'd0, frame_addr},  32'd0);
        check("rst_data",  {24'd0, frame_data},  32'd0);
        check("rst_busy",  {31'd0, busy},        32'd0);
        rst_n = 1'b1;
        clk_n(4);

        // Write frame 0x80F0
        send(32'h80F0, 16, 1'b0, 1'b1, 7'h00, 8'hF0);
        // Read frame 0x0455
        send(32'h0455, 16, 1'b0, 1'b0, 7'h04, 8'h55);
        // Short and long frames: errors, outputs hold the previous frame
        send(32'h7FFF, 15, 1'b1, 1'b0, 7'h04, 8'h55);
        send(32'h1ABCD, 17, 1'b1, 1'b0, 7'h04, 8'h55);
        // Back-to-back frames with 2 SCLK periods of nCS high between
        send(32'h8101, 16, 1'b0, 1'b1, 7'h01, 8'h01);
        send(32'h82FF, 16, 1'b0, 1'b1, 7'h02, 8'hFF);

        // Reset after 8 bits of 0x83AA, released with nCS still low
        ncs = 1'b0;
        clk_n(8);
        for (int i = 15; i >= 8; i--) begin
            copi = 1'(16'h83AA >> i);
            clk_n(4);
            sclk = 1'b1;
            clk_n(4);
            sclk = 1'b0;
        end
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        clk_n(3);
        check("midrst_rw",   {31'd0, frame_rw},   32'd0);
        check("midrst_addr", {25'd0, frame_addr}, 32'd0);
        check("midrst_data", {24'd0, frame_data}, 32'd0);
        check("midrst_busy", {31'd0, busy},       32'd0);
        rst_n = 1'b1;
        clk_n(10);
        check("postrst_busy", {31'd0, busy},       32'd1);
        check("postrst_addr", {25'd0, frame_addr}, 32'd0);
        clk_n(4);
        ncs = 1'b1;
        begin
            exp_t x;
            x.err = 1'b1; x.rw = 1'b0; x.addr = 7'h00; x.data = 8'h00; x.rise_cyc = cyc;
            sb_q.push_back(x);
        end
        clk_n(16);

        // Idle SCLK toggling with nCS high: no pulses, never busy
        for (int i = 0; i < 16; i++) begin
            copi = i[0];
            sclk = 1'b1;
            clk_n(4);
            check("idle_busy", {31'd0, busy}, 32'd0);
            sclk = 1'b0;
            clk_n(4);
        end

        // Drain the scoreboard with a bounded wait
        waited = 0;
        while (sb_q.size() != 0 && waited < 200) begin
            clk_n(1);
            waited++;
        end
        check("scoreboard_empty", sb_q.size(), 32'd0);
        check("final_addr", {25'd0, frame_addr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
